// File: rtl/secded_fault_injector.sv
// Fault injector between SECDED encoder and decoder: flips one, two or two adjacent
// codeword bits at LFSR-chosen positions, on an arm request or every period-th word.
module secded_fault_injector #(
    parameter int unsigned    W    = 39,
    parameter logic [15:0]    SEED = 16'hACE1,
    localparam int unsigned   PB   = $clog2(W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [W-1:0]     in_data,
    input  logic [1:0]       mode,
    input  logic             arm,
    input  logic [15:0]      period,
    output logic             out_valid,
    output logic [W-1:0]     out_data,
    output logic [W-1:0]     out_err_mask,
    output logic [15:0]      inj_count,
    output logic             pending
);

    localparam int unsigned RW        = PB + 1;
    localparam logic [15:0] SEED_EFF  = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [1:0]  MODE_NONE   = 2'b00;
    localparam logic [1:0]  MODE_SINGLE = 2'b01;
    localparam logic [1:0]  MODE_DOUBLE = 2'b10;
    localparam logic [1:0]  MODE_BURST  = 2'b11;

    logic [15:0]   lfsr_q,    lfsr_d;
    logic [15:0]   cnt_q,     cnt_d;
    logic          pending_q, pending_d;
    logic [15:0]   count_q,   count_d;
    logic          valid_q,   valid_d;
    logic [W-1:0]  data_q,    data_d;
    logic [W-1:0]  mask_q,    mask_d;

    logic [PB-1:0] p1_c;
    logic [PB-1:0] p1_next_c;
    logic [PB-1:0] p2_raw_c;
    logic [PB-1:0] p2_c;
    logic [W-1:0]  mask_c;
    logic          period_hit_c;
    logic          inj_c;

    // r < 2W, so one conditional subtraction maps r into 0..W-1.
    function automatic logic [PB-1:0] reduce_pos(input logic [PB-1:0] r);
        logic [RW-1:0] r_ext;
        r_ext = RW'(r);
        if (r_ext >= RW'(W)) begin
            r_ext = r_ext - RW'(W);
        end
        return PB'(r_ext);
    endfunction

    function automatic logic [PB-1:0] inc_wrap(input logic [PB-1:0] p);
        return (p == PB'(W - 1)) ? '0 : p + PB'(1);
    endfunction

    // Bit positions and injection mask from the current LFSR state
    always_comb begin
        p1_c      = reduce_pos(lfsr_q[PB-1:0]);
        p1_next_c = inc_wrap(p1_c);
        p2_raw_c  = reduce_pos(lfsr_q[8 +: PB]);
        p2_c      = (p2_raw_c == p1_c) ? p1_next_c : p2_raw_c;
        mask_c    = '0;
        case (mode)
            MODE_SINGLE: begin
                mask_c[p1_c] = 1'b1;
            end
            MODE_DOUBLE: begin
                mask_c[p1_c] = 1'b1;
                mask_c[p2_c] = 1'b1;
            end
            MODE_BURST: begin
                mask_c[p1_c]      = 1'b1;
                mask_c[p1_next_c] = 1'b1;
            end
            default: begin
                mask_c = '0;
            end
        endcase
    end

    // Injection decision and next-state logic
    always_comb begin
        period_hit_c = in_valid && (period != 16'd0) && (cnt_q == period - 16'd1);
        inj_c        = in_valid && (mode != MODE_NONE) && (pending_q || arm || period_hit_c);

        lfsr_d    = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
        cnt_d     = cnt_q;
        pending_d = pending_q;
        count_d   = count_q;
        valid_d   = in_valid;
        data_d    = '0;
        mask_d    = '0;

        if ((period == 16'd0) || (mode == MODE_NONE)) begin
            cnt_d = 16'd0;
        end else if (in_valid) begin
            cnt_d = (cnt_q >= period - 16'd1) ? 16'd0 : cnt_q + 16'd1;
        end

        if ((mode == MODE_NONE) || inj_c) begin
            pending_d = 1'b0;
        end else if (arm) begin
            pending_d = 1'b1;
        end

        if (inj_c && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end

        if (in_valid) begin
            mask_d = inj_c ? mask_c : '0;
            data_d = in_data ^ mask_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q    <= SEED_EFF;
            cnt_q     <= 16'd0;
            pending_q <= 1'b0;
            count_q   <= 16'd0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            mask_q    <= '0;
        end else begin
            lfsr_q    <= lfsr_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            count_q   <= count_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            mask_q    <= mask_d;
        end
    end

    assign out_valid    = valid_q;
    assign out_data     = data_q;
    assign out_err_mask = mask_q;
    assign inj_count    = count_q;
    assign pending      = pending_q;

endmodule

// File: tb/tb_secded_fault_injector.sv
// Directed and randomized bench for secded_fault_injector against a behavioural
// model of the injection rules.
module tb_secded_fault_injector;

    localparam int          W    = 39;
    localparam int          PB   = $clog2(W);
    localparam logic [15:0] SEED = 16'hACE1;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic [1:0]   mode;
    logic         arm;
    logic [15:0]  period;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic [W-1:0] out_err_mask;
    logic [15:0]  inj_count;
    logic         pending;

    int checks = 0;
    int errors = 0;

    logic [15:0]  m_lfsr;
    int           m_cnt;
    logic         m_pending;
    int           m_count;
    logic         last_inj;
    int           last_p1;
    logic [W-1:0] last_exp_m;
    logic [W-1:0] sig [8];

    secded_fault_injector #(.W(W), .SEED(SEED)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .mode         (mode),
        .arm          (arm),
        .period       (period),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_err_mask (out_err_mask),
        .inj_count    (inj_count),
        .pending      (pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd_word();
        return W'({$urandom(), $urandom()});
    endfunction

    // Positions are the low / second byte of the LFSR taken modulo W
    function automatic logic [W-1:0] model_mask(input logic [15:0] l, input logic [1:0] md,
                                                 output int p1);
        logic [W-1:0] m;
        int lv, p2;
        lv = int'(l);
        p1 = (lv % (2 ** PB)) % W;
        p2 = ((lv / 256) % (2 ** PB)) % W;
        if (md == 2'd3 || p2 == p1) p2 = (p1 + 1) % W;
        m = '0;
        if (md != 2'd0) m[p1] = 1'b1;
        if (md >= 2'd2) m[p2] = 1'b1;
        return m;
    endfunction

    // One clock: drive inputs, predict outputs, check after the edge
    task automatic step(input logic v, input logic [W-1:0] d, input logic [1:0] md,
                        input logic a, input logic [15:0] per, input logic r);
        logic [W-1:0] mask, exp_d, exp_m;
        logic         exp_v, hit, inj;
        int           p1;
        rst = r; in_valid = v; in_data = d; mode = md; arm = a; period = per;
        if (r) begin
            exp_v = 1'b0; exp_d = '0; exp_m = '0;
            m_lfsr = (SEED == 16'h0) ? 16'h0001 : SEED;
            m_cnt = 0; m_pending = 1'b0; m_count = 0;
            last_inj = 1'b0; last_p1 = -1;
        end else begin
            mask  = model_mask(m_lfsr, md, p1);
            hit   = v && (per != 16'd0) && (m_cnt == int'(per) - 1);
            inj   = v && (md != 2'd0) && (m_pending || a || hit);
            exp_v = v;
            exp_m = inj ? mask : '0;
            exp_d = v ? (d ^ exp_m) : '0;
            if (inj && m_count < 65535) m_count++;
            if (md == 2'd0 || inj) m_pending = 1'b0;
            else if (a) m_pending = 1'b1;
            if (per == 16'd0 || md == 2'd0) m_cnt = 0;
            else if (v) m_cnt = (m_cnt + 1) % int'(per);
            m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
            last_inj = inj; last_p1 = p1;
        end
        last_exp_m = exp_m;
        @(posedge clk);
        #1;
        check("out_valid", 64'(out_valid), 64'(exp_v));
        check("out_data", 64'(out_data), 64'(exp_d));
        check("out_err_mask", 64'(out_err_mask), 64'(exp_m));
        check("inj_count", 64'(inj_count), 64'(m_count));
        check("pending", 64'(pending), 64'(m_pending));
        check("mask_pop_le2", 64'($countones(out_err_mask) <= 2), 64'(1));
        if (out_valid) check("xor_invariant", 64'(out_data ^ d), 64'(out_err_mask));
    endtask

    initial begin
        logic seen_wrap;
        int   c0;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; mode = 2'b00; arm = 1'b0; period = 16'd0;

        // Reset state, then record a burst-mode signature for the post-reset replay
        step(1'b1, '0, 2'b00, 1'b0, 16'd0, 1'b1);
        check("rst_inj_count", 64'(inj_count), 64'(0));
        for (int i = 0; i < 8; i++) begin
            step(1'b1, W'(i * 7 + 3), 2'b11, 1'b0, 16'd1, 1'b0);
            sig[i] = last_exp_m;
        end
        step(1'b0, '0, 2'b00, 1'b0, 16'd0, 1'b1);

        // Single mode without triggers: pass-through
        for (int i = 0; i < 10; i++) begin
            step(1'b1, rnd_word(), 2'b01, 1'b0, 16'd0, 1'b0);
            check("passthru_mask", 64'(out_err_mask), 64'(0));
        end
        check("passthru_count", 64'(inj_count), 64'(0));

        // Arm while idle; pending waits three cycles for a word
        step(1'b0, '0, 2'b01, 1'b1, 16'd0, 1'b0);
        check("arm_pending", 64'(pending), 64'(1));
        for (int i = 0; i < 2; i++) begin
            step(1'b0, '0, 2'b01, 1'b0, 16'd0, 1'b0);
            check("arm_pending_hold", 64'(pending), 64'(1));
        end
        step(1'b1, W'(40'h55_5555_5555), 2'b01, 1'b0, 16'd0, 1'b0);
        check("arm_pop", 64'($countones(out_err_mask)), 64'(1));
        check("arm_count", 64'(inj_count), 64'(1));
        check("arm_pending_clr", 64'(pending), 64'(0));
        step(1'b1, rnd_word(), 2'b01, 1'b0, 16'd0, 1'b0);
        check("arm_once", 64'(out_err_mask), 64'(0));

        // Double mode every 4th word
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, rnd_word(), 2'b10, 1'b0, 16'd4, 1'b0);
            check("period4_pop", 64'($countones(out_err_mask)), 64'((i % 4 == 0) ? 2 : 0));
        end
        check("period4_count", 64'(inj_count), 64'(5));

        // Burst mode on every word until the wrap-around pair has been seen
        seen_wrap = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            step(1'b1, rnd_word(), 2'b11, 1'b0, 16'd1, 1'b0);
            check("burst_pop", 64'($countones(out_err_mask)), 64'(2));
            if (last_inj && last_p1 == W - 1) begin
                seen_wrap = 1'b1;
                check("burst_wrap", 64'(out_err_mask), 64'({1'b1, {(W - 2){1'b0}}, 1'b1}));
            end
            if (i >= 63 && seen_wrap) break;
        end

        // Arm coinciding with period hit, then a doubled arm while pending
        c0 = m_count;
        step(1'b1, rnd_word(), 2'b01, 1'b0, 16'd3, 1'b0);
        step(1'b1, rnd_word(), 2'b01, 1'b0, 16'd3, 1'b0);
        step(1'b1, rnd_word(), 2'b01, 1'b1, 16'd3, 1'b0);
        check("coincide_pop", 64'($countones(out_err_mask)), 64'(1));
        check("coincide_pending", 64'(pending), 64'(0));
        step(1'b0, '0, 2'b01, 1'b1, 16'd3, 1'b0);
        step(1'b0, '0, 2'b01, 1'b1, 16'd3, 1'b0);
        check("absorb_pending", 64'(pending), 64'(1));
        step(1'b1, rnd_word(), 2'b01, 1'b0, 16'd3, 1'b0);
        step(1'b1, rnd_word(), 2'b01, 1'b0, 16'd3, 1'b0);
        check("no_queued_inj", 64'(out_err_mask), 64'(0));
        check("coincide_count", 64'(inj_count), 64'(c0 + 2));

        // Randomized traffic with period 5
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), rnd_word(), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 7) == 0), 16'd5, 1'b0);
        end

        // Saturate the injection counter
        for (int i = 0; i < 70000 && m_count < 16'hFFFE; i++) begin
            step(1'b1, rnd_word(), 2'b01, 1'b0, 16'd1, 1'b0);
        end
        check("preload_count", 64'(inj_count), 64'(16'hFFFE));
        for (int i = 0; i < 3; i++) step(1'b1, rnd_word(), 2'b01, 1'b0, 16'd1, 1'b0);
        check("sat_count", 64'(inj_count), 64'(16'hFFFF));

        // Reset with a word present drops it; LFSR sequence restarts
        step(1'b1, rnd_word(), 2'b01, 1'b0, 16'd1, 1'b1);
        check("midrst_valid", 64'(out_valid), 64'(0));
        check("midrst_data", 64'(out_data), 64'(0));
        check("midrst_count", 64'(inj_count), 64'(0));
        for (int i = 0; i < 8; i++) begin
            step(1'b1, W'(i * 7 + 3), 2'b11, 1'b0, 16'd1, 1'b0);
            check("replay_mask", 64'(out_err_mask), 64'(sig[i]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
